// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions for the RV64 core.
//   XLEN / CTRL_W    : datapath and control-bundle widths
//   CTRL_*           : bit positions inside the control bundle,
//                      {regWrite, memRead, memWrite, memToReg, aluSrc, branch, aluOp[1:0]}
//   stage_state_e    : ID/EX stage FSM states
//   ctrl_pack()      : builds a control bundle from its fields
package riscv_pipe_pkg;
  localparam int XLEN   = 64;
  localparam int CTRL_W = 8;

  localparam int CTRL_REGWRITE = 7;
  localparam int CTRL_MEMREAD  = 6;
  localparam int CTRL_MEMWRITE = 5;
  localparam int CTRL_MEMTOREG = 4;
  localparam int CTRL_ALUSRC   = 3;
  localparam int CTRL_BRANCH   = 2;
  localparam int CTRL_ALUOP    = 0;
  localparam int CTRL_ALUOP_W  = 2;

  typedef enum logic {RUN = 1'b0, BUBBLE = 1'b1} stage_state_e;

  function automatic logic [CTRL_W-1:0] ctrl_pack(
    input logic rw, input logic mr, input logic mw, input logic m2r,
    input logic asrc, input logic br, input logic [CTRL_ALUOP_W-1:0] aluop);
    logic [CTRL_W-1:0] c;
    c = '0;
    c[CTRL_REGWRITE] = rw;
    c[CTRL_MEMREAD]  = mr;
    c[CTRL_MEMWRITE] = mw;
    c[CTRL_MEMTOREG] = m2r;
    c[CTRL_ALUSRC]   = asrc;
    c[CTRL_BRANCH]   = br;
    c[CTRL_ALUOP +: CTRL_ALUOP_W] = aluop;
    return c;
  endfunction
endpackage

// File: rtl/id_ex_stage_if.sv
// ID -> EX stage bus.
//   master : decode / writeback side (drives id_*, wb_*, flush; sees stall_id, ex_*)
//   slave  : the ID/EX pipeline register
interface id_ex_stage_if;
  import riscv_pipe_pkg::*;

  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [4:0]        id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0]   id_rdata1, id_rdata2, id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              flush;
  logic              wb_regwrite;
  logic [4:0]        wb_rd;
  logic [XLEN-1:0]   wb_data;

  logic              stall_id;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc, ex_imm, ex_rdata1, ex_rdata2;
  logic [4:0]        ex_rs1, ex_rs2, ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rdata1, id_rdata2, id_imm,
           id_ctrl, flush, wb_regwrite, wb_rd, wb_data,
    input  stall_id, ex_valid, ex_pc, ex_imm, ex_rdata1, ex_rdata2,
           ex_rs1, ex_rs2, ex_rd, ex_ctrl
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rdata1, id_rdata2, id_imm,
           id_ctrl, flush, wb_regwrite, wb_rd, wb_data,
    output stall_id, ex_valid, ex_pc, ex_imm, ex_rdata1, ex_rdata2,
           ex_rs1, ex_rs2, ex_rd, ex_ctrl
  );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard compare and writeback bypass selects (combinational).
//   hazard     : load in EX writes a register the ID instruction reads
//   byp1/byp2  : capture wb_data instead of rdata1/rdata2
// Bypass selects are live only when ID_EX_BYPASS_EN is defined; otherwise 0.
// x0 never matches in any compare.
module hazard_detect (
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       wb_regwrite,
  input  logic [4:0] wb_rd,
  output logic       hazard,
  output logic       byp1,
  output logic       byp2
);
  logic ld_live;
  assign ld_live = ex_valid & ex_memread & (ex_rd != 5'd0);
  assign hazard  = ld_live & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

`ifdef ID_EX_BYPASS_EN
  // Covers the regfile write-at-edge / read-before-write window.
  logic wb_live;
  assign wb_live = wb_regwrite & (wb_rd != 5'd0);
  assign byp1    = wb_live & (wb_rd == id_rs1);
  assign byp2    = wb_live & (wb_rd == id_rs2);
`else
  logic unused_wb;
  assign unused_wb = ^{wb_regwrite, wb_rd};
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush squash and event counters.
//   clk, reset  : clock, synchronous active-high reset
//   bus         : id_ex_stage_if.slave (ID/WB inputs, flush, stall_id, ex_* outputs)
//   bubble_cnt  : saturating count of inserted load-use bubbles
//   flush_cnt   : saturating count of flush edges
// Optional macro: ID_EX_BYPASS_EN enables write-through bypass of wb_data.
// Edge priority: reset > flush > hazard (bubble) > capture.
module id_ex_stage
  import riscv_pipe_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  id_ex_stage_if.slave     bus,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  logic hazard, byp1, byp2, bubble_ins;
  stage_state_e state_q, state_d;

  hazard_detect u_hd (
    .ex_valid    (bus.ex_valid),
    .ex_memread  (bus.ex_ctrl[CTRL_MEMREAD]),
    .ex_rd       (bus.ex_rd),
    .id_valid    (bus.id_valid),
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .wb_regwrite (bus.wb_regwrite),
    .wb_rd       (bus.wb_rd),
    .hazard      (hazard),
    .byp1        (byp1),
    .byp2        (byp2)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // FSM: next state. BUBBLE lasts exactly one edge since the bubble clears ex_valid.
  always_comb begin
    state_d = RUN;
    case (state_q)
      RUN:     if (hazard & ~bus.flush) state_d = BUBBLE;
      BUBBLE:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // FSM: outputs. Flush wins over the hazard, so no stall is raised under flush.
  always_comb begin
    bus.stall_id = hazard & ~bus.flush;
    bubble_ins   = hazard & ~bus.flush;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.ex_valid  <= 1'b0;
      bus.ex_ctrl   <= '0;
      bus.ex_pc     <= '0;
      bus.ex_imm    <= '0;
      bus.ex_rdata1 <= '0;
      bus.ex_rdata2 <= '0;
      bus.ex_rs1    <= '0;
      bus.ex_rs2    <= '0;
      bus.ex_rd     <= '0;
    end else if (bus.flush || bubble_ins) begin
      // Squash: payload fields are held, only valid/ctrl are cleared.
      bus.ex_valid <= 1'b0;
      bus.ex_ctrl  <= '0;
    end else begin
      bus.ex_valid  <= bus.id_valid;
      bus.ex_ctrl   <= bus.id_valid ? bus.id_ctrl : '0;
      bus.ex_pc     <= bus.id_pc;
      bus.ex_imm    <= bus.id_imm;
      bus.ex_rdata1 <= byp1 ? bus.wb_data : bus.id_rdata1;
      bus.ex_rdata2 <= byp2 ? bus.wb_data : bus.id_rdata2;
      bus.ex_rs1    <= bus.id_rs1;
      bus.ex_rs2    <= bus.id_rs2;
      bus.ex_rd     <= bus.id_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (bus.flush && flush_cnt != '1)   flush_cnt  <= flush_cnt + 1'b1;
      if (bubble_ins && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

  a_no_hazard_in_bubble: assert property (
    @(posedge clk) disable iff (reset) (state_q == BUBBLE) |-> !hazard);
endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  import riscv_pipe_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_stage_if ifm ();
  id_ex_stage_if ifs ();

  logic [31:0] bcnt, fcnt;
  logic [2:0]  sbcnt, sfcnt;

  id_ex_stage #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .bus(ifm.slave), .bubble_cnt(bcnt), .flush_cnt(fcnt));

  // Narrow-counter copy on the same stimulus, so saturation is reachable.
  id_ex_stage #(.CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .bus(ifs.slave), .bubble_cnt(sbcnt), .flush_cnt(sfcnt));

  assign ifs.id_valid    = ifm.id_valid;
  assign ifs.id_pc       = ifm.id_pc;
  assign ifs.id_rs1      = ifm.id_rs1;
  assign ifs.id_rs2      = ifm.id_rs2;
  assign ifs.id_rd       = ifm.id_rd;
  assign ifs.id_rdata1   = ifm.id_rdata1;
  assign ifs.id_rdata2   = ifm.id_rdata2;
  assign ifs.id_imm      = ifm.id_imm;
  assign ifs.id_ctrl     = ifm.id_ctrl;
  assign ifs.flush       = ifm.flush;
  assign ifs.wb_regwrite = ifm.wb_regwrite;
  assign ifs.wb_rd       = ifm.wb_rd;
  assign ifs.wb_data     = ifm.wb_data;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

`ifdef ID_EX_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- reference model: what EX should hold ----------------
  typedef struct {
    bit        valid;
    bit [4:0]  rs1, rs2, rd;
    bit [63:0] pc, imm, r1, r2;
    bit [7:0]  ctrl;
  } ex_t;
  ex_t mex;
  longint nb, nf;

  function automatic bit model_hazard();
    bit is_load;
    is_load = mex.valid && mex.ctrl[6] && mex.rd != 0;
    return is_load && ifm.id_valid && (mex.rd == ifm.id_rs1 || mex.rd == ifm.id_rs2);
  endfunction

  function automatic bit [63:0] operand(input bit [4:0] rs, input bit [63:0] rf);
    if (BYP && ifm.wb_regwrite && ifm.wb_rd != 0 && ifm.wb_rd == rs) return ifm.wb_data;
    return rf;
  endfunction

  task automatic model_edge(input bit hz);
    if (reset) begin
      mex = '{default: 0};
      nb = 0; nf = 0;
    end else if (ifm.flush) begin
      mex.valid = 0; mex.ctrl = 0; nf++;
    end else if (hz) begin
      mex.valid = 0; mex.ctrl = 0; nb++;
    end else begin
      mex.valid = ifm.id_valid;
      mex.ctrl  = ifm.id_valid ? ifm.id_ctrl : 8'h00;
      mex.pc = ifm.id_pc; mex.imm = ifm.id_imm;
      mex.rs1 = ifm.id_rs1; mex.rs2 = ifm.id_rs2; mex.rd = ifm.id_rd;
      mex.r1 = operand(ifm.id_rs1, ifm.id_rdata1);
      mex.r2 = operand(ifm.id_rs2, ifm.id_rdata2);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " ex_valid"}, ifm.ex_valid, mex.valid);
    chk({tag, " ex_ctrl"}, ifm.ex_ctrl, mex.ctrl);
    chk({tag, " bubble_cnt"}, bcnt, nb);
    chk({tag, " flush_cnt"}, fcnt, nf);
    chk({tag, " sat bubble_cnt"}, sbcnt, (nb > 7) ? 7 : nb);
    chk({tag, " sat flush_cnt"}, sfcnt, (nf > 7) ? 7 : nf);
    chk({tag, " sat ex_valid"}, ifs.ex_valid, mex.valid);
    if (mex.valid) begin
      chk({tag, " ex_pc"}, ifm.ex_pc, mex.pc);
      chk({tag, " ex_imm"}, ifm.ex_imm, mex.imm);
      chk({tag, " ex_rs1"}, ifm.ex_rs1, mex.rs1);
      chk({tag, " ex_rs2"}, ifm.ex_rs2, mex.rs2);
      chk({tag, " ex_rd"}, ifm.ex_rd, mex.rd);
      chk({tag, " ex_rdata1"}, ifm.ex_rdata1, mex.r1);
      chk({tag, " ex_rdata2"}, ifm.ex_rdata2, mex.r2);
    end
  endtask

  bit last_stall;

  // Called at posedge+1 with inputs already applied.
  task automatic step(input string tag);
    bit hz;
    hz = model_hazard();
    #1;
    chk({tag, " stall_id"}, ifm.stall_id, hz && !ifm.flush);
    last_stall = hz && !ifm.flush;
    model_edge(hz);
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic drive(input bit v, input bit [63:0] pc, input bit [4:0] rs1, rs2, rd,
                       input bit [63:0] r1, r2, imm, input bit [7:0] ctrl, input bit fl,
                       input bit wbw, input bit [4:0] wbrd, input bit [63:0] wbd);
    ifm.id_valid = v; ifm.id_pc = pc; ifm.id_rs1 = rs1; ifm.id_rs2 = rs2; ifm.id_rd = rd;
    ifm.id_rdata1 = r1; ifm.id_rdata2 = r2; ifm.id_imm = imm; ifm.id_ctrl = ctrl;
    ifm.flush = fl; ifm.wb_regwrite = wbw; ifm.wb_rd = wbrd; ifm.wb_data = wbd;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit        idv;
    bit [63:0] pc;
    bit [4:0]  rs1, rs2, rd;
    bit [63:0] r1, r2;
    bit [7:0]  ctrl;
    bit        fl, wbw;
    bit [4:0]  wbrd;
    bit [63:0] wbd;
    bit        e_stall, e_valid;
    bit [7:0]  e_ctrl;
    bit [4:0]  e_rd;
    bit [63:0] e_r2;
    int        e_b, e_f;
  } vec_t;

  function automatic vec_t mk(
    input bit idv, input bit [63:0] pc, input bit [4:0] rs1, rs2, rd,
    input bit [63:0] r1, r2, input bit [7:0] ctrl, input bit fl, wbw,
    input bit [4:0] wbrd, input bit [63:0] wbd,
    input bit e_stall, e_valid, input bit [7:0] e_ctrl, input bit [4:0] e_rd,
    input bit [63:0] e_r2, input int e_b, e_f);
    vec_t v;
    v.idv = idv; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.r1 = r1; v.r2 = r2;
    v.ctrl = ctrl; v.fl = fl; v.wbw = wbw; v.wbrd = wbrd; v.wbd = wbd;
    v.e_stall = e_stall; v.e_valid = e_valid; v.e_ctrl = e_ctrl; v.e_rd = e_rd;
    v.e_r2 = e_r2; v.e_b = e_b; v.e_f = e_f;
    return v;
  endfunction

  vec_t tv[10];

  initial begin
    vec_t t;
    bit [63:0] byp_r2;
    byp_r2 = BYP ? 64'hDEAD : 64'h8;

    //            v  pc     rs1 rs2 rd r1  r2     ctrl   fl wb wbrd wbd       stall v  ectrl erd er2    b  f
    tv[0] = mk(1, 64'h100, 3, 4, 1, 4,  5,     8'h80, 0, 0, 0, 0,         0, 1, 8'h80, 1, 5,      0, 0); // plain capture
    tv[1] = mk(1, 64'h104, 1, 0, 5, 0,  0,     8'hD8, 0, 0, 0, 0,         0, 1, 8'hD8, 5, 0,      0, 0); // ld x5
    tv[2] = mk(1, 64'h108, 5, 6, 7, 11, 22,    8'h82, 0, 0, 0, 0,         1, 0, 8'h00, 0, 0,      1, 0); // add uses x5 -> bubble
    tv[3] = mk(1, 64'h108, 5, 6, 7, 11, 22,    8'h82, 0, 0, 0, 0,         0, 1, 8'h82, 7, 22,     1, 0); // recaptured
    tv[4] = mk(1, 64'h10C, 2, 0, 0, 0,  0,     8'hD8, 0, 0, 0, 0,         0, 1, 8'hD8, 0, 0,      1, 0); // ld x0
    tv[5] = mk(1, 64'h110, 0, 0, 3, 0,  9,     8'h82, 0, 0, 0, 0,         0, 1, 8'h82, 3, 9,      1, 0); // x0 never matches
    tv[6] = mk(1, 64'h114, 1, 2, 5, 0,  0,     8'hD8, 0, 0, 0, 0,         0, 1, 8'hD8, 5, 0,      1, 0); // ld x5
    tv[7] = mk(1, 64'h118, 5, 6, 7, 0,  0,     8'h82, 1, 0, 0, 0,         0, 0, 8'h00, 0, 0,      1, 1); // flush beats hazard
    tv[8] = mk(1, 64'h11C, 1, 7, 8, 0,  8,     8'h82, 0, 1, 7, 64'hDEAD,  0, 1, 8'h82, 8, byp_r2, 1, 1); // wb bypass
    tv[9] = mk(0, 64'h120, 8, 8, 9, 0,  0,     8'hFF, 0, 0, 0, 0,         0, 0, 8'h00, 0, 0,      1, 1); // invalid -> ctrl 0

    // reset state
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset ex_valid", ifm.ex_valid, 0);
    chk("reset ex_ctrl", ifm.ex_ctrl, 0);
    chk("reset ex_pc", ifm.ex_pc, 0);
    chk("reset ex_rdata1", ifm.ex_rdata1, 0);
    chk("reset bubble_cnt", bcnt, 0);
    chk("reset flush_cnt", fcnt, 0);
    chk("reset stall_id", ifm.stall_id, 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      string tag;
      t = tv[i];
      tag = $sformatf("vec%0d", i);
      drive(t.idv, t.pc, t.rs1, t.rs2, t.rd, t.r1, t.r2, 64'h0, t.ctrl, t.fl, t.wbw, t.wbrd, t.wbd);
      #1;
      chk({tag, " stall_id"}, ifm.stall_id, t.e_stall);
      @(posedge clk); #1;
      chk({tag, " ex_valid"}, ifm.ex_valid, t.e_valid);
      chk({tag, " ex_ctrl"}, ifm.ex_ctrl, t.e_ctrl);
      chk({tag, " bubble_cnt"}, bcnt, t.e_b);
      chk({tag, " flush_cnt"}, fcnt, t.e_f);
      if (t.e_valid) begin
        chk({tag, " ex_rd"}, ifm.ex_rd, t.e_rd);
        chk({tag, " ex_rdata2"}, ifm.ex_rdata2, t.e_r2);
        chk({tag, " ex_pc"}, ifm.ex_pc, t.pc);
      end
    end

    // ---------------- reset asserted mid-stall ----------------
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    step("rst_sync");
    reset = 1'b0;
    drive(1, 64'h200, 1, 2, 5, 64'h1, 64'h2, 64'h3, 8'hD8, 0, 0, 0, 0);
    step("mid ld");
    drive(1, 64'h204, 5, 3, 6, 64'h4, 64'h5, 64'h6, 8'h82, 0, 0, 0, 0);
    step("mid stall");
    chk("mid stall raised", last_stall, 1);
    reset = 1'b1;
    step("mid reset");
    chk("mid reset ex_valid", ifm.ex_valid, 0);
    chk("mid reset ex_pc", ifm.ex_pc, 0);
    chk("mid reset ex_rdata1", ifm.ex_rdata1, 0);
    chk("mid reset ex_rd", ifm.ex_rd, 0);
    chk("mid reset bubble_cnt", bcnt, 0);
    chk("mid reset flush_cnt", fcnt, 0);
    chk("mid reset stall_id", ifm.stall_id, 0);
    reset = 1'b0;

    // ---------------- randomized run against the model ----------------
    last_stall = 0;
    for (int c = 0; c < 600; c++) begin
      if (!last_stall) begin
        bit [7:0] ctl;
        ctl = 8'($urandom);
        ctl[6] = ($urandom_range(0, 1) == 1);
        ifm.id_valid  = ($urandom_range(0, 9) < 8);
        ifm.id_pc     = {$urandom, $urandom};
        ifm.id_rs1    = 5'($urandom_range(0, 7));
        ifm.id_rs2    = 5'($urandom_range(0, 7));
        ifm.id_rd     = 5'($urandom_range(0, 7));
        ifm.id_rdata1 = {$urandom, $urandom};
        ifm.id_rdata2 = {$urandom, $urandom};
        ifm.id_imm    = {$urandom, $urandom};
        ifm.id_ctrl   = ctl;
      end
      ifm.flush       = ($urandom_range(0, 9) == 0);
      ifm.wb_regwrite = ($urandom_range(0, 1) == 1);
      ifm.wb_rd       = 5'($urandom_range(0, 7));
      ifm.wb_data     = {$urandom, $urandom};
      step($sformatf("rnd%0d", c));
    end
    chk("sat bubble_cnt pinned", sbcnt, (nb >= 7) ? 3'd7 : 3'(nb));
    chk("sat flush_cnt pinned", sfcnt, (nf >= 7) ? 3'd7 : 3'(nf));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between the decode stage (register-file read) and the execute stage of the 64-bit RISC-V pipeline. Each cycle it captures the decoded instruction: PC, register indices, both register-file read operands, immediate and control bundle. It detects load-use hazards, stalls decode and inserts a bubble, and squashes on a taken-branch flush. It also keeps saturating bubble and flush event counters for performance debug.

## Interface
- XLEN, 64, datapath width
- CTRL_W, 8, control bundle width: {regWrite, memRead, memWrite, memToReg, aluSrc, branch, aluOp[1:0]}, MSB first
- CNT_W, 32, event counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- id_valid  in  1  decode holds a valid instruction
- id_pc  in  XLEN  instruction PC
- id_rs1, id_rs2, id_rd  in  5  register indices
- id_rdata1, id_rdata2  in  XLEN  register-file read data for rs1/rs2
- id_imm  in  XLEN  sign-extended immediate
- id_ctrl  in  CTRL_W  control bundle
- flush  in  1  taken branch resolved in EX; kill younger instructions
- wb_regwrite  in  1  writeback write enable (same signal that drives the register file)
- wb_rd  in  5  writeback destination
- wb_data  in  XLEN  writeback data
- stall_id  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  EX holds a valid instruction
- ex_pc, ex_imm, ex_rdata1, ex_rdata2  out  XLEN  registered copies
- ex_rs1, ex_rs2, ex_rd  out  5  registered copies
- ex_ctrl  out  CTRL_W  registered control; all-zero when not valid
- bubble_cnt, flush_cnt  out  CNT_W  event counters

## Operation
- Hazard: `hazard = ex_valid & ex_ctrl.memRead & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2)`.
- Index 0 never matches in either hazard or bypass compares.
- `stall_id = hazard & ~flush`. This output is combinational.
- Per-edge priority: reset, then flush, then hazard, then capture.
  - **reset:** all outputs are 0.
  - **flush:** ex_valid=0 and ex_ctrl=0. Other ex_* fields are don't-care but held. flush_cnt increments.
  - **hazard:** bubble inserted (ex_valid=0, ex_ctrl=0). bubble_cnt increments. Decode is held by stall_id.
  - **capture:** ex_valid<=id_valid and all id_* fields are copied. ex_ctrl<=id_valid ? id_ctrl : 0.
- FSM states:
  - RUN: normal operation.
  - BUBBLE: a bubble is in EX.
  - RUN→BUBBLE when hazard & ~flush.
  - BUBBLE→RUN unconditionally on the next edge. The bubble clears the hazard, so the stall is exactly one cycle.
  - Any state→RUN on flush or reset.
  - In BUBBLE, hazard is impossible by construction. An assertion checks this.
- Counters saturate at all-ones and do not wrap.

## Timing
- Latency: ID inputs appear on ex_* one cycle after the capturing edge.
- stall_id is valid in the same cycle as the offending ID inputs. The held instruction is recaptured on the edge after the bubble.
- flush in the same cycle as hazard: flush wins, stall_id=0, no bubble_cnt increment.
- reset asserted mid-stall: the next edge yields RUN, ex_valid=0 and both counters 0.

## Configuration
- The feature is controlled by the macro ID_EX_BYPASS_EN.
- **Defined (write-through bypass):** if `wb_regwrite & wb_rd!=0 & wb_rd==id_rs1`, ex_rdata1 captures wb_data instead of id_rdata1. The same rule applies to rs2 and ex_rdata2. This covers the register file's write-at-edge / read-before-write window.
- **Undefined:** id_rdata1/2 are captured unmodified, and same-cycle WB hazards are left to the EX forwarding unit.

## Structure
- Package riscv_pipe_pkg holds:
  - XLEN and CTRL_W.
  - Bit-index localparams for each control field (CTRL_REGWRITE … CTRL_ALUOP).
  - The state enum {RUN, BUBBLE}.
- One sub-module, hazard_detect: a combinational compare producing hazard and the two bypass selects.
- id_ex_stage holds the register, FSM and counters.

## Test plan
- **Plain capture:** id_valid=1, pc=0x100, rs1=3, rs2=4, rdata1=4, rdata2=5, ctrl=0x80 → next cycle ex_valid=1, same values, stall_id=0.
- **Load-use:**
  - EX holds ld with rd=5 (memRead=1); ID presents add with rs1=5.
  - Required: stall_id=1 that cycle, then ex_valid=0, ex_ctrl=0, bubble_cnt=1.
  - The add is captured one cycle later.
- **x0 exclusion:** EX ld rd=0, ID rs1=0 → stall_id=0, no bubble.
- **Flush vs hazard:** load-use condition with flush=1 → stall_id=0, ex_valid=0, flush_cnt=1, bubble_cnt=0.
- **Bypass (macro on):**
  - wb_regwrite=1, wb_rd=7, wb_data=0xDEAD, id_rs2=7, id_rdata2=8 → ex_rdata2=0xDEAD.
  - With the macro off → ex_rdata2=8.
- **Reset mid-stall and counter saturation:**
  - Assert reset in BUBBLE → all outputs 0.
  - Preload bubble_cnt to 0xFFFFFFFF and trigger a hazard → it stays 0xFFFFFFFF.
